// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state encodings, opcode constants and opcode classification
// shared by the control sequencer and its timer.
`default_nettype none
`timescale 1ns/1ps
package cpu_ctrl_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_FETCH     = 3'd1;
   localparam logic [2:0] ST_DECODE    = 3'd2;
   localparam logic [2:0] ST_REGREAD   = 3'd3;
   localparam logic [2:0] ST_EXECUTE   = 3'd4;
   localparam logic [2:0] ST_MEMORY    = 3'd5;
   localparam logic [2:0] ST_WRITEBACK = 3'd6;
   localparam logic [2:0] ST_HALTED    = 3'd7;

   localparam logic [3:0] OP_LOAD  = 4'b1000;
   localparam logic [3:0] OP_STORE = 4'b1001;
   localparam logic [3:0] OP_JUMP  = 4'b1100;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic logic has_writeback(input logic [3:0] op);
      return !((op == OP_STORE) || (op == OP_JUMP) || (op == OP_HALT));
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory-wait cycles and flags the cycle
// on which the MEM_WAIT_MAX-th consecutive wait would occur.
`default_nettype none
`timescale 1ns/1ps
module mem_wait_timer #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_count,
   output logic o_timeout
);

   logic [7:0] r_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= 8'd0;
      end else if (i_clear) begin
         r_cnt <= 8'd0;
      end else if (i_count && (r_cnt != 8'hFF)) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // r_cnt holds the waits already seen, so this is the MEM_WAIT_MAX-th one
   assign o_timeout = i_count && (r_cnt == 8'(MEM_WAIT_MAX - 1));

endmodule
`default_nettype wire

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: multi-cycle fetch/decode/regread/execute/memory/
// writeback control FSM with halt handling and memory-timeout fault.
`default_nettype none
`timescale 1ns/1ps
module cpu_control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             run,
   input  logic             halt_req,
   input  logic [3:0]       opcode,
   input  logic             mem_ready,
   output logic             en_fetch,
   output logic             en_decode,
   output logic             en_regread,
   output logic             en_alu,
   output logic             en_mem,
   output logic             en_regwrite,
   output logic [2:0]       state,
   output logic             busy,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] instr_count
);

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [3:0]       r_op;
   logic             r_run_q;
   logic             r_fault;
   logic [CNT_W-1:0] r_count;
   logic             w_count;
   logic             w_clear;
   logic             w_timeout;
   logic             w_retire;
   logic             w_run_rise;

   assign w_count    = ((r_state == ST_FETCH) || (r_state == ST_MEMORY)) && !mem_ready;
   assign w_clear    = !w_count;
   assign w_run_rise = run && !r_run_q;

   mem_wait_timer #(
      .MEM_WAIT_MAX (MEM_WAIT_MAX)
   ) u_mem_wait_timer (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_clear   (w_clear),
      .i_count   (w_count),
      .o_timeout (w_timeout)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (run) w_next = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_ready)      w_next = ST_DECODE;
            else if (w_timeout) w_next = ST_HALTED;
         end
         ST_DECODE: begin
            w_next = ST_REGREAD;
         end
         ST_REGREAD: begin
            w_next = (opcode == OP_HALT) ? ST_HALTED : ST_EXECUTE;
         end
         ST_EXECUTE: begin
            if (is_mem_op(r_op))          w_next = ST_MEMORY;
            else if (has_writeback(r_op)) w_next = ST_WRITEBACK;
            else                          w_retire = 1'b1;
         end
         ST_MEMORY: begin
            if (mem_ready) begin
               if (has_writeback(r_op)) w_next = ST_WRITEBACK;
               else                     w_retire = 1'b1;
            end else if (w_timeout) begin
               w_next = ST_HALTED;
            end
         end
         ST_WRITEBACK: begin
            w_retire = 1'b1;
         end
         ST_HALTED: begin
            if (w_run_rise) w_next = ST_IDLE;
         end
      endcase
      // run/halt_req only matter at an instruction boundary
      if (w_retire) begin
         if (halt_req) w_next = ST_HALTED;
         else if (run) w_next = ST_FETCH;
         else          w_next = ST_IDLE;
      end
   end

   always_comb begin
      en_fetch    = (r_state == ST_FETCH);
      en_decode   = (r_state == ST_DECODE);
      en_regread  = (r_state == ST_REGREAD);
      en_alu      = (r_state == ST_EXECUTE);
      en_mem      = (r_state == ST_MEMORY);
      en_regwrite = (r_state == ST_WRITEBACK);
      busy        = (r_state != ST_IDLE) && (r_state != ST_HALTED);
      halted      = (r_state == ST_HALTED);
      state       = r_state;
      fault       = r_fault;
      instr_count = r_count;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_op    <= 4'd0;
         r_run_q <= 1'b0;
         r_fault <= 1'b0;
         r_count <= '0;
      end else begin
         r_run_q <= run;
         if (r_state == ST_REGREAD) r_op <= opcode;
         if (w_timeout)                                r_fault <= 1'b1;
         else if ((r_state == ST_HALTED) && w_run_rise) r_fault <= 1'b0;
         if (w_retire) r_count <= r_count + 1'b1;
      end
   end

endmodule
`default_nettype wire
